pe_cell_apb_regbank: RTL and testbench

PE_CELL_APB_REGBANK -- requirements
Module: pe_cell_apb_regbank

---
 rtl/pe_cell_apb_regbank_if.sv | 24 ++
 rtl/pe_cell_apb_regbank.sv | 193 +++++++++++++++++++
 tb/tb_pe_cell_apb_regbank.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_cell_apb_regbank_if.sv
// pe_cell_apb_regbank_if: APB slave bus bundle for the PE cell register bank.
interface pe_cell_apb_regbank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/pe_cell_apb_regbank.sv
// pe_cell_apb_regbank: APB register bank with shadow/active PE configuration and status/irq.
// Define PE_REG_PSLVERR_EN to flag unmapped, read-only and commit-pending writes with pslverr.
module pe_cell_apb_regbank #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 4,
  parameter int WAIT_CYC = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pe_cell_apb_regbank_if.slave     apb,
  input  logic                     pe_busy,
  input  logic                     pe_done,
  input  logic                     pe_ovf,
  output logic                     start_pulse,
  output logic [NUM_CH*DATA_W-1:0] set_cycle,
  output logic [7:0]               reuse,
  output logic                     irq
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_REUSE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_IRQ_EN  = ADDR_W'(3);
  localparam logic [7:0]        REUSE_RST = 8'h61;
  localparam logic [DATA_W-1:0] SET_RST   = DATA_W'(2);

  state_e            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic              setup_ph, access_ph, xfer_ready, bad, wr_en, rd_next;
  logic              hit_ctrl, hit_reuse, hit_status, hit_irq_en;
  logic [NUM_CH-1:0] hit_ch;
  logic [DATA_W-1:0] rd_data;
  logic              commit, copy;
  logic [1:0]        w1c;

  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [7:0]        reuse_sh_q, reuse_sh_d, reuse_act_q, reuse_act_d;
  logic [DATA_W-1:0] set_sh_q  [NUM_CH];
  logic [DATA_W-1:0] set_sh_d  [NUM_CH];
  logic [DATA_W-1:0] set_act_q [NUM_CH];
  logic [DATA_W-1:0] set_act_d [NUM_CH];
  logic              done_q, done_d, ovf_q, ovf_d, pend_q, pend_d;
  logic [1:0]        irq_en_q, irq_en_d;
  logic              start_q, start_d, irq_q, irq_d;

  assign setup_ph  = apb.psel & ~apb.penable;
  assign access_ph = apb.psel &  apb.penable;

  // state_q is the phase sampled at the last edge: S_SETUP marks the first ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops update with <= so every register in the edge sees pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    // NOTE: defaults come first so no branch leaves a signal unassigned (no latch).
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (setup_ph) begin
          state_d = S_SETUP;
          wait_d  = 3'(WAIT_CYC);
        end
      end
      S_SETUP, S_ACCESS: begin
        if (!apb.psel) begin
          state_d = S_IDLE;
        end else if (access_ph) begin
          if (wait_q == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ACCESS;
            wait_d  = wait_q - 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xfer_ready = (state_q != S_IDLE) && access_ph && (wait_q == '0);
    wr_en      = xfer_ready & apb.pwrite & ~bad;
    rd_next    = (state_d != S_IDLE) && (wait_d == '0) && !apb.pwrite;
  end

  assign apb.pready  = xfer_ready;
  assign apb.pslverr = xfer_ready & bad;
  assign apb.prdata  = prdata_q;

  always_comb begin
    hit_ctrl   = (apb.paddr == A_CTRL);
    hit_reuse  = (apb.paddr == A_REUSE);
    hit_status = (apb.paddr == A_STATUS);
    hit_irq_en = (apb.paddr == A_IRQ_EN);
    for (int i = 0; i < NUM_CH; i++) hit_ch[i] = (apb.paddr == ADDR_W'(4 + i));

    rd_data = '0;
    if (hit_reuse)  rd_data = DATA_W'(reuse_sh_q);
    if (hit_status) rd_data = DATA_W'({pend_q, ovf_q, done_q});
    if (hit_irq_en) rd_data = DATA_W'(irq_en_q);
    for (int i = 0; i < NUM_CH; i++) if (hit_ch[i]) rd_data = set_sh_q[i];

    bad = 1'b0;
`ifdef PE_REG_PSLVERR_EN
    bad = ~(hit_ctrl | hit_reuse | hit_status | hit_irq_en | (|hit_ch))
        | (apb.pwrite & hit_status & apb.pwdata[2])
        | (apb.pwrite & pend_q & ~hit_ctrl & ~hit_status);
`endif
  end

  always_comb begin
    reuse_sh_d  = reuse_sh_q;
    reuse_act_d = reuse_act_q;
    set_sh_d    = set_sh_q;
    set_act_d   = set_act_q;
    irq_en_d    = irq_en_q;

    // A commit seen while the array runs is parked until pe_busy drops.
    commit  = wr_en & hit_ctrl & apb.pwdata[1];
    copy    = ~pe_busy & (commit | pend_q);
    pend_d  = pe_busy & (commit | pend_q);
    start_d = wr_en & hit_ctrl & apb.pwdata[0];

    // Set pulses override a simultaneous write-1-to-clear.
    w1c    = (wr_en & hit_status) ? apb.pwdata[1:0] : 2'b00;
    done_d = pe_done | (done_q & ~w1c[0]);
    ovf_d  = pe_ovf  | (ovf_q  & ~w1c[1]);
    irq_d  = |({ovf_q, done_q} & irq_en_q);

    if (wr_en & hit_reuse)  reuse_sh_d = apb.pwdata[7:0];
    if (wr_en & hit_irq_en) irq_en_d   = apb.pwdata[1:0];
    for (int i = 0; i < NUM_CH; i++) if (wr_en & hit_ch[i]) set_sh_d[i] = apb.pwdata;

    if (copy) begin
      reuse_act_d = reuse_sh_q;
      set_act_d   = set_sh_q;
    end

    prdata_d = rd_next ? rd_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata_q    <= '0;
      reuse_sh_q  <= REUSE_RST;
      reuse_act_q <= REUSE_RST;
      // NOTE: these arrays are configuration registers, not RAM, so every entry is reset.
      for (int i = 0; i < NUM_CH; i++) begin
        set_sh_q[i]  <= SET_RST;
        set_act_q[i] <= SET_RST;
      end
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      irq_en_q <= '0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      prdata_q    <= prdata_d;
      reuse_sh_q  <= reuse_sh_d;
      reuse_act_q <= reuse_act_d;
      set_sh_q    <= set_sh_d;
      set_act_q   <= set_act_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      irq_en_q    <= irq_en_d;
      start_q     <= start_d;
      irq_q       <= irq_d;
    end
  end

  assign start_pulse = start_q;
  assign reuse       = reuse_act_q;
  assign irq         = irq_q;

  always_comb begin
    set_cycle = '0;
    for (int i = 0; i < NUM_CH; i++) set_cycle[i*DATA_W +: DATA_W] = set_act_q[i];
  end

endmodule

// File: tb/tb_pe_cell_apb_regbank.sv
// tb_pe_cell_apb_regbank: bench for pe_cell_apb_regbank with WAIT_CYC=3, NUM_CH=4, DATA_W=32.
`timescale 1ns/1ps
module tb_pe_cell_apb_regbank;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int NUM_CH   = 4;
  localparam int WAIT_CYC = 3;
`ifdef PE_REG_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pe_busy = 1'b0, pe_done = 1'b0, pe_ovf = 1'b0;
  logic start_pulse, irq;
  logic [NUM_CH*DATA_W-1:0] set_cycle;
  logic [7:0] reuse;

  pe_cell_apb_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pe_cell_apb_regbank #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .apb(bus),
    .pe_busy(pe_busy), .pe_done(pe_done), .pe_ovf(pe_ovf),
    .start_pulse(start_pulse), .set_cycle(set_cycle), .reuse(reuse), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;
  exp_t sb_q[$];

  logic [DATA_W-1:0] m_sh [NUM_CH];
  logic [DATA_W-1:0] m_act[NUM_CH];
  logic [7:0]        m_reuse_sh, m_reuse_act;

  function automatic logic [NUM_CH*DATA_W-1:0] pack_act();
    logic [NUM_CH*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = m_act[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_sh[i]  = 32'h2;
      m_act[i] = 32'h2;
    end
    m_reuse_sh  = 8'h61;
    m_reuse_act = 8'h61;
  endtask

  task automatic model_commit();
    for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
    m_reuse_act = m_reuse_sh;
  endtask

  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic done_on_ready, output logic [DATA_W-1:0] rdata,
                          output logic err, output int acc);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    acc = 0; rdata = '0; err = 1'b0;
    while (1) begin
      @(negedge clk);
      acc++;
      if (bus.pready === 1'b1) begin
        rdata = bus.prdata;
        err   = bus.pslverr;
        break;
      end
      n_vec++;
      if (bus.prdata !== '0) begin
        n_bad++;
        $display("FAIL prdata_wait addr=%h: got %h want 0", addr, bus.prdata);
      end
      if (acc >= 32) begin
        n_bad++;
        $display("FAIL pready_timeout addr=%h: got no pready within %0d cycles", addr, acc);
        break;
      end
      @(posedge clk); #1;
    end
    if (done_on_ready) pe_done = 1'b1;
    @(posedge clk); #1;
    pe_done = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp_data,
                          input logic exp_err, input string name);
    exp_t e;
    logic [DATA_W-1:0] rd;
    logic er;
    int acc;
    e.addr = addr; e.data = exp_data; e.err = exp_err;
    sb_q.push_back(e);
    apb_xfer(1'b0, addr, '0, 1'b0, rd, er, acc);
    e = sb_q.pop_front();
    n_vec++;
    if (rd !== e.data) begin
      n_bad++; $display("FAIL %s rdata addr=%h: got %h want %h", name, e.addr, rd, e.data);
    end
    n_vec++;
    if (er !== e.err) begin
      n_bad++; $display("FAIL %s pslverr addr=%h: got %b want %b", name, e.addr, er, e.err);
    end
    n_vec++;
    if (acc !== WAIT_CYC + 1) begin
      n_bad++; $display("FAIL %s access_cycles: got %0d want %0d", name, acc, WAIT_CYC + 1);
    end
    @(negedge clk);
    n_vec++;
    if (bus.prdata !== '0) begin
      n_bad++; $display("FAIL %s prdata_after: got %h want 0", name, bus.prdata);
    end
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic exp_err, input logic done_on_ready);
    logic [DATA_W-1:0] rd;
    logic er;
    int acc;
    apb_xfer(1'b1, addr, data, done_on_ready, rd, er, acc);
    n_vec++;
    if (er !== exp_err) begin
      n_bad++; $display("FAIL wr_pslverr addr=%h: got %b want %b", addr, er, exp_err);
    end
    n_vec++;
    if (acc !== WAIT_CYC + 1) begin
      n_bad++; $display("FAIL wr_access_cycles addr=%h: got %0d want %0d", addr, acc, WAIT_CYC + 1);
    end
    if (!exp_err) begin
      if (addr == 6'h01) m_reuse_sh = data[7:0];
      for (int i = 0; i < NUM_CH; i++) if (addr == 6'(4 + i)) m_sh[i] = data;
    end
  endtask

  task automatic check_active(input string name);
    n_vec++;
    if (set_cycle !== pack_act()) begin
      n_bad++; $display("FAIL %s set_cycle: got %h want %h", name, set_cycle, pack_act());
    end
    n_vec++;
    if (reuse !== m_reuse_act) begin
      n_bad++; $display("FAIL %s reuse: got %h want %h", name, reuse, m_reuse_act);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.pready, bus.pslverr, start_pulse, irq} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl_outs: got %b want 0000", {bus.pready, bus.pslverr, start_pulse, irq});
    end
    n_vec++;
    if (bus.prdata !== '0) begin
      n_bad++; $display("FAIL reset_prdata: got %h want 0", bus.prdata);
    end
    check_active("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb_read(6'h01, 32'h61, 1'b0, "reset_reuse");
    apb_read(6'h04, 32'h2,  1'b0, "reset_set0");
    apb_read(6'h02, 32'h0,  1'b0, "reset_status");
    apb_read(6'h07, 32'h2,  1'b0, "reset_set3");
    apb_read(6'h03, 32'h0,  1'b0, "reset_irq_en");
    apb_read(6'h00, 32'h0,  1'b0, "ctrl_reads_0");
  endtask

  task automatic test_wait_commit();
    apb_write(6'h04, 32'h10, 1'b0, 1'b0);
    apb_write(6'h05, 32'hABCD_1234, 1'b0, 1'b0);
    apb_write(6'h01, 32'h1234_56A5, 1'b0, 1'b0);
    apb_read(6'h01, 32'hA5, 1'b0, "reuse_trunc");
    apb_read(6'h05, 32'hABCD_1234, 1'b0, "set1_shadow");
    check_active("before_commit");
    apb_write(6'h00, 32'h2, 1'b0, 1'b0);
    model_commit();
    @(negedge clk);
    check_active("after_commit");
    n_vec++;
    if (start_pulse !== 1'b0) begin
      n_bad++; $display("FAIL commit_no_start: got %b want 0", start_pulse);
    end
  endtask

  task automatic test_pending();
    pe_busy = 1'b1;
    apb_write(6'h04, 32'h33, 1'b0, 1'b0);
    apb_write(6'h00, 32'h2, 1'b0, 1'b0);
    apb_read(6'h02, 32'h4, 1'b0, "status_pending");
    apb_write(6'h06, 32'h77, ERR_EN, 1'b0);
    @(negedge clk);
    check_active("while_busy");
    @(posedge clk); #1;
    pe_busy = 1'b0;
    model_commit();
    @(posedge clk); #1;
    @(negedge clk);
    check_active("busy_dropped");
    apb_read(6'h02, 32'h0, 1'b0, "status_pend_clr");
  endtask

  task automatic test_irq();
    apb_write(6'h03, 32'hFFFF_FFFD, 1'b0, 1'b0);
    apb_read(6'h03, 32'h1, 1'b0, "irq_en_trunc");
    @(posedge clk); #1;
    pe_done = 1'b1;
    @(posedge clk); #1;
    pe_done = 1'b0;
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL irq_latency: got %b want 0", irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin
      n_bad++; $display("FAIL irq_set: got %b want 1", irq);
    end
    apb_write(6'h02, 32'h1, 1'b0, 1'b1);
    apb_read(6'h02, 32'h1, 1'b0, "done_set_wins");
    n_vec++;
    if (irq !== 1'b1) begin
      n_bad++; $display("FAIL irq_held: got %b want 1", irq);
    end
    apb_write(6'h02, 32'h1, 1'b0, 1'b0);
    apb_read(6'h02, 32'h0, 1'b0, "done_w1c");
    n_vec++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL irq_clr: got %b want 0", irq);
    end
    @(posedge clk); #1;
    pe_ovf = 1'b1;
    @(posedge clk); #1;
    pe_ovf = 1'b0;
    apb_read(6'h02, 32'h2, 1'b0, "ovf_set");
    n_vec++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL irq_ovf_masked: got %b want 0", irq);
    end
    apb_write(6'h02, 32'h2, 1'b0, 1'b0);
    apb_read(6'h02, 32'h0, 1'b0, "ovf_w1c");
  endtask

  task automatic test_start_commit();
    apb_write(6'h07, 32'h5A5A, 1'b0, 1'b0);
    apb_write(6'h01, 32'h3C, 1'b0, 1'b0);
    apb_write(6'h00, 32'h3, 1'b0, 1'b0);
    model_commit();
    @(negedge clk);
    n_vec++;
    if (start_pulse !== 1'b1) begin
      n_bad++; $display("FAIL start_pulse_hi: got %b want 1", start_pulse);
    end
    check_active("start_commit");
    @(negedge clk);
    n_vec++;
    if (start_pulse !== 1'b0) begin
      n_bad++; $display("FAIL start_pulse_width: got %b want 0", start_pulse);
    end
    pe_busy = 1'b1;
    apb_write(6'h00, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (start_pulse !== 1'b1) begin
      n_bad++; $display("FAIL start_busy_hi: got %b want 1", start_pulse);
    end
    @(negedge clk);
    n_vec++;
    if (start_pulse !== 1'b0) begin
      n_bad++; $display("FAIL start_busy_width: got %b want 0", start_pulse);
    end
    pe_busy = 1'b0;
    apb_read(6'h02, 32'h0, 1'b0, "start_no_pend");
  endtask

  task automatic test_unmapped();
    apb_read(6'h3F, 32'h0, ERR_EN, "unmapped_3f");
    apb_read(6'h08, 32'h0, ERR_EN, "unmapped_08");
    apb_write(6'h3F, 32'hFFFF_FFFF, ERR_EN, 1'b0);
    apb_write(6'h02, 32'h4, ERR_EN, 1'b0);
    apb_read(6'h02, 32'h0, 1'b0, "status_bit2_ro");
    apb_read(6'h07, 32'h5A5A, 1'b0, "set3_intact");
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 6'h01; bus.pwdata = 32'hEE;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.pready !== 1'b0) begin
      n_bad++; $display("FAIL abort_pready: got %b want 0", bus.pready);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    apb_read(6'h01, 32'h61, 1'b0, "abort_no_write");
    check_active("abort_reset");
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    test_reset();
    test_wait_commit();
    test_pending();
    test_irq();
    test_start_commit();
    test_unmapped();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
